// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite blitter: FSM state encoding,
// default frame-buffer geometry and the transparent palette index.
package sprite_pkg;

    localparam int FB_W_DEFAULT       = 640;
    localparam int FB_H_DEFAULT       = 480;
    localparam int TRANSP_IDX_DEFAULT = 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        WAIT  = ST_WAIT,
        WRITE = ST_WRITE,
        DONE  = ST_DONE
    } blit_state_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_raster_counter.sv
// Raster walker over the sprite: pixel coordinates (sx, sy) plus the linear
// ROM address, which simply increments so no multiply is needed on the ROM side.
module sprite_raster_counter
    import sprite_pkg::*;
#(
    parameter int SPR_W  = 268,
    parameter int SPR_H  = 200,
    parameter int ROM_AW = 16,
    parameter int SX_W   = cnt_w(SPR_W),
    parameter int SY_W   = cnt_w(SPR_H)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              adv,
    output logic [SX_W-1:0]   sx,
    output logic [SY_W-1:0]   sy,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              last
);

    logic [SX_W-1:0]   sx_reg, sx_next;
    logic [SY_W-1:0]   sy_reg, sy_next;
    logic [ROM_AW-1:0] rom_addr_reg, rom_addr_next;
    logic              sx_end;
    logic              sy_end;

    assign sx_end = (sx_reg == SX_W'(SPR_W - 1));
    assign sy_end = (sy_reg == SY_W'(SPR_H - 1));

    always_comb begin
        sx_next       = sx_reg;
        sy_next       = sy_reg;
        rom_addr_next = rom_addr_reg;
        if (clr) begin
            sx_next       = '0;
            sy_next       = '0;
            rom_addr_next = '0;
        end else if (adv) begin
            rom_addr_next = rom_addr_reg + 1'b1;
            if (sx_end) begin
                sx_next = '0;
                sy_next = sy_end ? '0 : sy_reg + 1'b1;
            end else begin
                sx_next = sx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_reg       <= '0;
            sy_reg       <= '0;
            rom_addr_reg <= '0;
        end else begin
            sx_reg       <= sx_next;
            sy_reg       <= sy_next;
            rom_addr_reg <= rom_addr_next;
        end
    end

    assign sx       = sx_reg;
    assign sy       = sy_reg;
    assign rom_addr = rom_addr_reg;
    assign last     = sx_end && sy_end;

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from its palette-index ROM into the frame buffer at (x0,y0),
// skipping transparent and off-screen pixels; writes use an fb_we/fb_ready handshake.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 268,
    parameter int SPR_H      = 200,
    parameter int FB_W       = FB_W_DEFAULT,
    parameter int FB_H       = FB_H_DEFAULT,
    parameter int ROM_AW     = 16,
    parameter int FB_AW      = 19,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = TRANSP_IDX_DEFAULT
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [9:0]        x0,
    input  logic [9:0]        y0,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [IDX_W-1:0]  fb_data,
    input  logic              fb_ready
);

    localparam int SX_W = cnt_w(SPR_W);
    localparam int SY_W = cnt_w(SPR_H);

    blit_state_t       state_reg, state_next;
    logic [9:0]        x0_reg, y0_reg;
    logic [FB_AW-1:0]  fb_addr_reg, fb_addr_next;
    logic [IDX_W-1:0]  fb_data_reg, fb_data_next;

    logic              cnt_clr;
    logic              cnt_adv;
    logic [SX_W-1:0]   sx;
    logic [SY_W-1:0]   sy;
    logic              last;

    logic [10:0]       x_sum;
    logic [10:0]       y_sum;
    logic              on_screen;
    logic              skip;

    sprite_raster_counter #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ROM_AW (ROM_AW),
        .SX_W   (SX_W),
        .SY_W   (SY_W)
    ) u_raster (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .clr      (cnt_clr),
        .adv      (cnt_adv),
        .sx       (sx),
        .sy       (sy),
        .rom_addr (rom_addr),
        .last     (last)
    );

    // 11-bit sums cannot wrap, so an origin near the right/bottom edge clips cleanly.
    assign x_sum     = {1'b0, x0_reg} + 11'(sx);
    assign y_sum     = {1'b0, y0_reg} + 11'(sy);
    assign on_screen = (x_sum < 11'(FB_W)) && (y_sum < 11'(FB_H));
    assign skip      = (rom_q == IDX_W'(TRANSP_IDX)) || !on_screen;

    always_comb begin
        state_next   = state_reg;
        cnt_clr      = 1'b0;
        cnt_adv      = 1'b0;
        fb_addr_next = fb_addr_reg;
        fb_data_next = fb_data_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    cnt_clr    = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = WAIT;
            WAIT: begin
                if (skip) begin
                    cnt_adv    = 1'b1;
                    state_next = last ? DONE : FETCH;
                end else begin
                    // Only reached for in-range coordinates, so the product never overflows.
                    fb_addr_next = FB_AW'(y_sum) * FB_AW'(FB_W) + FB_AW'(x_sum);
                    fb_data_next = rom_q;
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                if (fb_ready) begin
                    cnt_adv    = 1'b1;
                    state_next = last ? DONE : FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            x0_reg      <= '0;
            y0_reg      <= '0;
            fb_addr_reg <= '0;
            fb_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            fb_addr_reg <= fb_addr_next;
            fb_data_reg <= fb_data_next;
            if (state_reg == IDLE && start) begin
                x0_reg <= x0;
                y0_reg <= y0;
            end
        end
    end

    // Status decoded straight from the state flop: fb_we falls with an async reset.
    assign busy    = (state_reg == FETCH) || (state_reg == WAIT) || (state_reg == WRITE);
    assign done    = (state_reg == DONE);
    assign fb_we   = (state_reg == WRITE);
    assign fb_addr = fb_addr_reg;
    assign fb_data = fb_data_reg;

endmodule
